// File: rtl/comm_route_matrix.sv
`default_nettype none
// ============================================================================
//  Module      : comm_route_matrix
//  Description : Host <-> N_DEV device UART route-through switch with rx
//                synchronisers, idle-safe route changes and a guard period.
//  Revision    : 1.0 - initial release
// ============================================================================

module comm_route_matrix #(
    parameter int N_DEV        = 2,
    parameter int SEL_W        = 1,
    parameter int IDLE_CYCLES  = 16,
    parameter int GUARD_CYCLES = 4,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SEL_W-1:0] sw_sel,
    input  logic             host_rx,
    output logic             host_tx,
    input  logic [N_DEV-1:0] dev_rx,
    output logic [N_DEV-1:0] dev_tx,
    output logic [SEL_W-1:0] active_sel,
    output logic             sw_pending,
    output logic             sel_err
);

    typedef enum logic [1:0] {
        ST_ROUTE = 2'd0,
        ST_DRAIN = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    localparam logic [SEL_W:0]   NDEV_V     = (SEL_W+1)'(N_DEV);
    localparam logic [CNT_W-1:0] IDLE_MAX   = CNT_W'(IDLE_CYCLES);
    localparam int               GUARD_EFF  = (GUARD_CYCLES < 1) ? 1 : GUARD_CYCLES;
    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_EFF);

    state_t             state_q, state_d;
    logic               host_s1_q, host_s2_q;
    logic [N_DEV-1:0]   dev_s1_q, dev_s2_q;
    logic [SEL_W-1:0]   active_sel_q, active_sel_d;
    logic               pending_q, pending_d;
    logic               sel_err_q;
    logic               host_tx_q, host_tx_d;
    logic [N_DEV-1:0]   dev_tx_q, dev_tx_d;
    logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [CNT_W-1:0]   guard_cnt_q, guard_cnt_d;

    logic               sel_oor;
    logic               sel_rx_s;
    logic               line_idle;

    assign sel_oor   = ({1'b0, sw_sel} >= NDEV_V);
    assign line_idle = host_s2_q & sel_rx_s;

    // Mux of the synchronised rx line of the currently routed device
    always_comb begin
        sel_rx_s = 1'b1;
        for (int i = 0; i < N_DEV; i++) begin
            if (active_sel_q == SEL_W'(i)) begin
                sel_rx_s = dev_s2_q[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        active_sel_d = active_sel_q;
        pending_d    = pending_q;
        guard_cnt_d  = guard_cnt_q;
        host_tx_d    = 1'b1;
        dev_tx_d     = '1;

        if (!line_idle) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q < IDLE_MAX) begin
            idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end else begin
            idle_cnt_d = idle_cnt_q;
        end

        if (state_q != ST_GUARD) begin
            host_tx_d = sel_rx_s;
            for (int i = 0; i < N_DEV; i++) begin
                if (active_sel_q == SEL_W'(i)) begin
                    dev_tx_d[i] = host_s2_q;
                end
            end
        end

        case (state_q)
            ST_ROUTE: begin
                if (!sel_oor && (sw_sel != active_sel_q)) begin
                    state_d   = ST_DRAIN;
                    pending_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                // Withdrawing the request wins over a switch due this same cycle
                if (sel_oor || (sw_sel == active_sel_q)) begin
                    state_d   = ST_ROUTE;
                    pending_d = 1'b0;
                end else if (idle_cnt_q == IDLE_MAX) begin
                    active_sel_d = sw_sel;
                    state_d      = ST_GUARD;
                    guard_cnt_d  = GUARD_LOAD;
                end
            end
            ST_GUARD: begin
                guard_cnt_d = guard_cnt_q - CNT_W'(1);
                if (guard_cnt_q <= CNT_W'(1)) begin
                    state_d    = ST_ROUTE;
                    pending_d  = 1'b0;
                    idle_cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_ROUTE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            host_s1_q    <= 1'b1;
            host_s2_q    <= 1'b1;
            dev_s1_q     <= '1;
            dev_s2_q     <= '1;
            state_q      <= ST_ROUTE;
            active_sel_q <= '0;
            pending_q    <= 1'b0;
            sel_err_q    <= 1'b0;
            host_tx_q    <= 1'b1;
            dev_tx_q     <= '1;
            idle_cnt_q   <= '0;
            guard_cnt_q  <= '0;
        end else begin
            host_s1_q    <= host_rx;
            host_s2_q    <= host_s1_q;
            dev_s1_q     <= dev_rx;
            dev_s2_q     <= dev_s1_q;
            state_q      <= state_d;
            active_sel_q <= active_sel_d;
            pending_q    <= pending_d;
            sel_err_q    <= sel_oor;
            host_tx_q    <= host_tx_d;
            dev_tx_q     <= dev_tx_d;
            idle_cnt_q   <= idle_cnt_d;
            guard_cnt_q  <= guard_cnt_d;
        end
    end

    assign host_tx    = host_tx_q;
    assign dev_tx     = dev_tx_q;
    assign active_sel = active_sel_q;
    assign sw_pending = pending_q;
    assign sel_err    = sel_err_q;

endmodule

`default_nettype wire

// File: tb/tb_comm_route_matrix.sv
`default_nettype none
// ============================================================================
//  Module      : tb_comm_route_matrix
//  Description : Self-checking bench for comm_route_matrix (3 devices).
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_comm_route_matrix;

    localparam int N     = 3;
    localparam int IDLE  = 16;
    localparam int GUARD = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [1:0]   sw_sel = 2'd0;
    logic         host_rx = 1'b1;
    logic         host_tx;
    logic [N-1:0] dev_rx = '1;
    logic [N-1:0] dev_tx;
    logic [1:0]   active_sel;
    logic         sw_pending;
    logic         sel_err;

    int n_cmp = 0;
    int n_err = 0;

    comm_route_matrix #(
        .N_DEV(N), .SEL_W(2), .IDLE_CYCLES(IDLE), .GUARD_CYCLES(GUARD), .CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .sw_sel(sw_sel), .host_rx(host_rx), .host_tx(host_tx),
        .dev_rx(dev_rx), .dev_tx(dev_tx), .active_sel(active_sel),
        .sw_pending(sw_pending), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    logic [7:0] dut_vec;
    assign dut_vec = {host_tx, dev_tx, active_sel, sw_pending, sel_err};

    // Reference model: pins seen two edges late, phases route/drain/guard,
    // an unbounded quiet-run length instead of a saturating counter.
    int           m_phase;   // 0 route, 1 drain, 2 guard
    int           m_act, m_run, m_guard_left;
    bit           m_pend, e_host, e_err;
    bit [N-1:0]   e_dev;
    bit           h_p1, h_p2;
    bit [N-1:0]   d_p1, d_p2;
    logic [7:0]   exp_vec;

    always @(posedge clk or posedge reset) begin
        bit hs, quiet, leave;
        bit [N-1:0] ds;
        int sel;
        if (reset) begin
            m_phase = 0; m_act = 0; m_run = 0; m_guard_left = 0; m_pend = 0;
            e_host = 1; e_dev = '1; e_err = 0;
            h_p1 = 1; h_p2 = 1; d_p1 = '1; d_p2 = '1;
        end else begin
            hs = h_p2; ds = d_p2;
            h_p2 = h_p1; h_p1 = host_rx;
            d_p2 = d_p1; d_p1 = dev_rx;
            sel   = int'(sw_sel);
            e_err = (sel >= N);
            quiet = hs && ds[m_act];
            e_dev = '1;
            if (m_phase == 2) begin
                e_host = 1;
            end else begin
                e_host = ds[m_act];
                e_dev[m_act] = hs;
            end
            leave = 0;
            if (m_phase == 0) begin
                if (sel < N && sel != m_act) begin m_phase = 1; m_pend = 1; end
            end else if (m_phase == 1) begin
                if (sel >= N || sel == m_act) begin
                    m_phase = 0; m_pend = 0;
                end else if (m_run >= IDLE) begin
                    m_act = sel; m_phase = 2; m_guard_left = GUARD;
                end
            end else begin
                if (m_guard_left == 1) begin m_phase = 0; m_pend = 0; leave = 1; end
                else m_guard_left--;
            end
            m_run = leave ? 0 : (quiet ? m_run + 1 : 0);
        end
        exp_vec = {e_host, e_dev, 2'(m_act), m_pend, e_err};
    end

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if (dut_vec !== 8'b1_111_00_0_0) begin
            n_err++; $display("FAIL reset_state got %b want %b", dut_vec, 8'b1_111_00_0_0);
        end
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        host_rx = 1'b0; dev_rx = 3'b110;
        @(negedge clk); @(negedge clk);
        n_cmp++;
        if (dev_tx !== 3'b111) begin n_err++; $display("FAIL latency_early got %b want 111", dev_tx); end
        @(negedge clk);
        n_cmp++;
        if ({host_tx, dev_tx} !== 4'b0_110) begin
            n_err++; $display("FAIL latency_3clk got %b want 0110", {host_tx, dev_tx});
        end
        for (int c = 0; c < 40; c++) begin
            if (c < 12) begin host_rx = 1'($urandom); dev_rx = 3'($urandom); end
            else begin host_rx = 1'b1; dev_rx = '1; end
            @(negedge clk);
            n_cmp++;
            if (dut_vec !== exp_vec) begin n_err++; $display("FAIL reset_route got %b want %b", dut_vec, exp_vec); end
        end
    endtask

    task automatic test_idle_switch();
        int seen = -1;
        sw_sel = 2'd2;
        @(negedge clk);
        n_cmp++;
        if (sw_pending !== 1'b1) begin n_err++; $display("FAIL pending_set got %b want 1", sw_pending); end
        for (int c = 0; c < 40 && seen < 0; c++) begin
            @(negedge clk);
            n_cmp++;
            if (dut_vec !== exp_vec) begin n_err++; $display("FAIL idle_switch got %b want %b", dut_vec, exp_vec); end
            if (active_sel === 2'd2) seen = c;
        end
        n_cmp++;
        if (seen < 0) begin n_err++; $display("FAIL switch_timeout got active %0d want 2", active_sel); end
        host_rx = 1'b0;
        for (int g = 0; g < GUARD; g++) begin
            @(negedge clk);
            n_cmp++;
            if ({host_tx, dev_tx} !== 4'b1111) begin
                n_err++; $display("FAIL guard_forced got %b want 1111", {host_tx, dev_tx});
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({dev_tx, sw_pending} !== 4'b011_0) begin
            n_err++; $display("FAIL new_route got %b want 0110", {dev_tx, sw_pending});
        end
        host_rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_busy_line();
        sw_sel = 2'd1;
        for (int c = 0; c < 50; c++) begin
            if (c % 10 == 0) dev_rx[2] = (c % 20 == 0) ? 1'b0 : 1'b1;
            @(negedge clk);
            n_cmp++;
            if (dut_vec !== exp_vec) begin n_err++; $display("FAIL busy_drain got %b want %b", dut_vec, exp_vec); end
        end
        n_cmp++;
        if ({active_sel, sw_pending} !== 3'b10_1) begin
            n_err++; $display("FAIL busy_hold got %b want 101", {active_sel, sw_pending});
        end
        dev_rx[2] = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            n_cmp++;
            if (dut_vec !== exp_vec) begin n_err++; $display("FAIL busy_release got %b want %b", dut_vec, exp_vec); end
            if (k == IDLE + 2 && active_sel !== 2'd2) begin
                n_err++; $display("FAIL switch_early got %0d want 2", active_sel);
            end
            if (k == IDLE + 3 && active_sel !== 2'd1) begin
                n_err++; $display("FAIL switch_edge got %0d want 1", active_sel);
            end
        end
    endtask

    task automatic test_cancel();
        sw_sel = 2'd2;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (sw_pending !== 1'b1) begin n_err++; $display("FAIL cancel_pending got %b want 1", sw_pending); end
        sw_sel = 2'd1; host_rx = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({active_sel, sw_pending} !== 3'b01_0) begin
            n_err++; $display("FAIL cancel_drop got %b want 010", {active_sel, sw_pending});
        end
        @(negedge clk); @(negedge clk);
        n_cmp++;
        if (dev_tx !== 3'b101) begin n_err++; $display("FAIL cancel_noguard got %b want 101", dev_tx); end
    endtask

    task automatic test_out_of_range();
        sw_sel = 2'd3;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({sel_err, sw_pending} !== 2'b10) begin
                n_err++; $display("FAIL oor_nodrain got %b want 10", {sel_err, sw_pending});
            end
        end
        sw_sel = 2'd0;
        @(negedge clk); @(negedge clk);
        n_cmp++;
        if ({sel_err, sw_pending} !== 2'b01) begin
            n_err++; $display("FAIL oor_drain got %b want 01", {sel_err, sw_pending});
        end
        sw_sel = 2'd3;
        @(negedge clk);
        n_cmp++;
        if ({sel_err, sw_pending, active_sel} !== 4'b10_01) begin
            n_err++; $display("FAIL oor_cancel got %b want 1001", {sel_err, sw_pending, active_sel});
        end
        sw_sel = 2'd1; host_rx = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (dut_vec !== exp_vec) begin n_err++; $display("FAIL oor_clear got %b want %b", dut_vec, exp_vec); end
    endtask

    task automatic test_reset_in_guard();
        bit hit = 0;
        repeat (20) @(negedge clk);
        sw_sel = 2'd2;
        for (int c = 0; c < 40 && !hit; c++) begin
            @(negedge clk);
            if (active_sel === 2'd2 && sw_pending === 1'b1) hit = 1;
        end
        n_cmp++;
        if (!hit) begin n_err++; $display("FAIL guard_timeout got active %0d want 2", active_sel); end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (dut_vec !== 8'b1_111_00_0_0 || exp_vec !== 8'b1_111_00_0_0) begin
            n_err++; $display("FAIL reset_guard got %b want %b", dut_vec, 8'b1_111_00_0_0);
        end
        @(negedge clk);
        reset = 1'b0; sw_sel = 2'd0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        bit quiet = 1;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            n_cmp++;
            if (dut_vec !== exp_vec) begin n_err++; $display("FAIL random c=%0d got %b want %b", c, dut_vec, exp_vec); end
            if (c % 40 == 0) quiet = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 24) == 0) sw_sel = 2'($urandom_range(0, 3));
            if (quiet) begin host_rx = 1'b1; dev_rx = '1; end
            else begin host_rx = 1'($urandom); dev_rx = 3'($urandom); end
        end
    endtask

    initial begin
        test_reset();
        test_idle_switch();
        test_busy_line();
        test_cancel();
        test_out_of_range();
        test_reset_in_guard();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
